keypad_scan: RTL

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// ============================================================================
// Module      : keypad_scan
// Description : 4x4 matrix keypad scanner. Drives one row low at a time,
//               samples the active-low columns at the end of each row dwell,
//               classifies each complete 16-key frame (none / single key /
//               ghost), debounces the frame result and emits key-press
//               events through a one-entry valid/ready buffer.
//
// Parameters  : SCAN_INTERVAL   - row dwell is SCAN_INTERVAL+1 clk cycles
//               DEBOUNCE_FRAMES - identical frames needed to accept a change
//                                 (1..15)
// Ports       : clk       in   single rising-edge clock
//               rst_n     in   asynchronous active-low reset
//               row[3:0]  out  row drive, active-low, one row low at a time
//               col[3:0]  in   column sense, active-low, asynchronous to clk
//               key_code  out  code of pending event (row*4 + col)
//               key_valid out  pending-event flag, held until accepted
//               key_ready in   consumer accept
//               key_down  out  high while a debounced key is held
//               overflow  out  sticky, set when an event is dropped
// Config      : define KEYPAD_COL_SYNC_EN to pass col through a 2-flop
//               synchronizer before sampling (needs SCAN_INTERVAL >= 3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scan #(
    parameter int SCAN_INTERVAL   = 10_000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_down,
    output logic       overflow
);

    localparam int                 c_CNT_W   = (SCAN_INTERVAL < 2) ? 1 : $clog2(SCAN_INTERVAL + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(SCAN_INTERVAL);
    localparam logic [3:0]         c_DEB_MAX = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Row scan timing
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_dwell_cnt;
    logic [1:0]         r_row_idx;
    logic               w_dwell_end;
    logic               w_frame_end;

    assign w_dwell_end = (r_dwell_cnt == c_CNT_MAX);
    assign w_frame_end = w_dwell_end && (r_row_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell_cnt <= '0;
            r_row_idx   <= 2'd0;
        end else if (w_dwell_end) begin
            r_dwell_cnt <= '0;
            r_row_idx   <= r_row_idx + 2'd1;
        end else begin
            r_dwell_cnt <= r_dwell_cnt + c_CNT_W'(1);
        end
    end

    assign row = ~(4'b0001 << r_row_idx);

    // ------------------------------------------------------------------
    // Column sampling (active-high "key hit" view of the columns)
    // ------------------------------------------------------------------
    logic [3:0] w_col_hit;

`ifdef KEYPAD_COL_SYNC_EN
    // The synchronized value seen at the end of the dwell reflects col two
    // cycles earlier, which is still inside the same row's dwell as long as
    // the dwell is at least four cycles long, so event timing is unchanged.
    logic [3:0] r_col_meta;
    logic [3:0] r_col_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_meta <= 4'b1111;
            r_col_sync <= 4'b1111;
        end else begin
            r_col_meta <= col;
            r_col_sync <= r_col_meta;
        end
    end

    assign w_col_hit = ~r_col_sync;
`else
    assign w_col_hit = ~col;
`endif

    logic [15:0] r_snap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap <= 16'd0;
        end else if (w_dwell_end) begin
            r_snap[{r_row_idx, 2'b00} +: 4] <= w_col_hit;
        end
    end

    // ------------------------------------------------------------------
    // Frame classification. The row-3 bits are taken straight from the
    // sample being captured so the frame is judged on the completing edge.
    // ------------------------------------------------------------------
    logic [15:0] w_frame;
    logic        w_ghost;
    logic        w_res_key;
    logic [3:0]  w_pri_idx;
    logic [3:0]  w_res_idx;

    always_comb begin
        w_frame         = r_snap;
        w_frame[15:12]  = w_col_hit;
        // More than one bit set <=> clearing the lowest set bit leaves bits.
        w_ghost         = ((w_frame & (w_frame - 16'd1)) != 16'd0);
        w_res_key       = (w_frame != 16'd0) && !w_ghost;
        w_pri_idx       = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_frame[i]) begin
                w_pri_idx = 4'(i);
            end
        end
        // NONE is encoded as key=0, idx=0 so result compares are exact.
        w_res_idx = w_res_key ? w_pri_idx : 4'd0;
    end

    // ------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------
    logic       r_prev_key;
    logic [3:0] r_prev_idx;
    logic [3:0] r_deb_cnt;
    logic       w_same;
    logic [3:0] w_deb_next;
    logic       w_frame_ok;
    logic       w_settled;

    assign w_same     = (w_res_key == r_prev_key) && (w_res_idx == r_prev_idx);
    assign w_deb_next = !w_same                 ? 4'd1 :
                        (r_deb_cnt >= c_DEB_MAX) ? c_DEB_MAX :
                                                  r_deb_cnt + 4'd1;
    assign w_frame_ok = w_frame_end && !w_ghost;
    // Once saturated the state already agrees with the result, so
    // re-evaluating on further identical frames changes nothing.
    assign w_settled  = w_frame_ok && (w_deb_next == c_DEB_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb_cnt  <= 4'd0;
            r_prev_key <= 1'b0;
            r_prev_idx <= 4'd0;
        end else if (w_frame_ok) begin
            r_deb_cnt  <= w_deb_next;
            r_prev_key <= w_res_key;
            r_prev_idx <= w_res_idx;
        end
    end

    // ------------------------------------------------------------------
    // Press state machine
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_held_idx;
    logic [3:0] w_held_nxt;
    logic       w_emit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_held_idx <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_held_idx <= w_held_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_held_nxt  = r_held_idx;
        w_emit      = 1'b0;
        if (w_settled) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_res_key) begin
                        w_state_nxt = ST_PRESSED;
                        w_held_nxt  = w_res_idx;
                        w_emit      = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!w_res_key) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_res_idx != r_held_idx) begin
                        w_held_nxt  = w_res_idx;
                        w_emit      = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign key_down = (r_state == ST_PRESSED);

    // ------------------------------------------------------------------
    // One-entry event buffer
    // ------------------------------------------------------------------
    logic       r_valid;
    logic [3:0] r_code;
    logic       r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_code  <= 4'd0;
            r_ovf   <= 1'b0;
        end else if (w_emit) begin
            if (!r_valid || key_ready) begin
                // Empty, or draining this cycle: the new event takes the slot.
                r_valid <= 1'b1;
                r_code  <= w_res_idx;
            end else begin
                // Slot occupied and not draining: keep the old event.
                r_ovf   <= 1'b1;
            end
        end else if (r_valid && key_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign key_valid = r_valid;
    assign key_code  = r_code;
    assign overflow  = r_ovf;

endmodule

`default_nettype wire
